// File: rtl/ram_clr.sv
// Parametrised single-port RAM with optional registered read and a hardware clear engine
// that sweeps every address to CLEAR_VAL, one word per cycle.
module ram_clr #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 64,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0,
    parameter int unsigned      REG_OUT   = 0,
    localparam int unsigned     ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [WIDTH-1:0]  in_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              clear_i,
    output logic [WIDTH-1:0]  out_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_cnt;
    logic [WIDTH-1:0]   r_mem [DEPTH];

    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [WIDTH-1:0]   w_wdata;

    // Counter is held at zero outside a sweep, so it is ready at every accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_CLEAR)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (clear_i) w_next = S_CLEAR;
            S_CLEAR: if (r_cnt == ADDR_W'(DEPTH - 1)) w_next = S_DONE;
            S_DONE:  w_next = clear_i ? S_CLEAR : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The sweep owns the write port while clearing; a reset edge aborts it without writing.
    always_comb begin
        busy_o  = (r_state == S_CLEAR);
        done_o  = (r_state == S_DONE);
        w_we    = load_i;
        w_waddr = address_i;
        w_wdata = in_i;
        if (r_state == S_CLEAR) begin
            w_we    = !rst_i;
            w_waddr = r_cnt;
            w_wdata = CLEAR_VAL;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] r_out;
            // Write-first: a same-edge write to the read address is forwarded.
            always_ff @(posedge clk_i) begin
                if (rst_i)
                    r_out <= '0;
                else if (w_we && (w_waddr == address_i))
                    r_out <= w_wdata;
                else
                    r_out <= r_mem[address_i];
            end
            assign out_o = r_out;
        end else begin : g_comb_out
            assign out_o = r_mem[address_i];
        end
    endgenerate

endmodule

// File: tb/tb_ram_clr.sv
// Directed bench for ram_clr: combinational and registered read instances, plus a small
// 8x8 instance with a non-zero fill value, checked through an expected-value queue.
module tb_ram_clr;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 16x64, combinational read
    logic [15:0] a_in, a_out;
    logic [5:0]  a_addr;
    logic        a_rst, a_load, a_clear, a_busy, a_done;
    // Instance B: 16x64, registered read
    logic [15:0] b_in, b_out;
    logic [5:0]  b_addr;
    logic        b_rst, b_load, b_clear, b_busy, b_done;
    // Instance C: 8x8, fill 0x5A, combinational read
    logic [7:0]  c_in, c_out;
    logic [2:0]  c_addr;
    logic        c_rst, c_load, c_clear, c_busy, c_done;

    ram_clr #(.WIDTH(16), .DEPTH(64), .REG_OUT(0)) u_a (
        .clk_i(clk), .rst_i(a_rst), .in_i(a_in), .load_i(a_load), .address_i(a_addr),
        .clear_i(a_clear), .out_o(a_out), .busy_o(a_busy), .done_o(a_done));

    ram_clr #(.WIDTH(16), .DEPTH(64), .REG_OUT(1)) u_b (
        .clk_i(clk), .rst_i(b_rst), .in_i(b_in), .load_i(b_load), .address_i(b_addr),
        .clear_i(b_clear), .out_o(b_out), .busy_o(b_busy), .done_o(b_done));

    ram_clr #(.WIDTH(8), .DEPTH(8), .CLEAR_VAL(8'h5A), .REG_OUT(0)) u_c (
        .clk_i(clk), .rst_i(c_rst), .in_i(c_in), .load_i(c_load), .address_i(c_addr),
        .clear_i(c_clear), .out_o(c_out), .busy_o(c_busy), .done_o(c_done));

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [15:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t x;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            x = sb.pop_front();
            assert (obs === x.exp) else begin
                fails++;
                $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
            end
        end
    endtask

    // Runs instance A from cycle 1 after a clear was accepted; cycle n drives edge k+n.
    task automatic sweep_a(input int clr_at, input int ld_lo, input int ld_hi, input int rst_at,
                           output int busy_cnt, output int done_cnt, output int done_at);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        for (int n = 1; n <= 80; n++) begin
            if (a_busy) busy_cnt++;
            if (a_done) begin
                done_cnt++;
                if (done_at == 0) done_at = n;
            end
            a_clear = (n == clr_at);
            a_load  = (n >= ld_lo) && (n <= ld_hi);
            a_addr  = 6'd50;
            a_in    = 16'h7777;
            a_rst   = (n == rst_at);
            tick();
        end
        a_clear = 1'b0;
        a_load  = 1'b0;
        a_rst   = 1'b0;
    endtask

    task automatic fill_a(input logic [15:0] v);
        a_load = 1'b1;
        a_in   = v;
        for (int i = 0; i < 64; i++) begin
            a_addr = 6'(i);
            tick();
        end
        a_load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc, da;

        a_in = '0; a_addr = '0; a_load = 0; a_clear = 0; a_rst = 1;
        b_in = '0; b_addr = '0; b_load = 0; b_clear = 0; b_rst = 1;
        c_in = '0; c_addr = '0; c_load = 0; c_clear = 0; c_rst = 1;
        tick();
        tick();

        push("rst_a_busy", 16'h0); pop_check({15'b0, a_busy});
        push("rst_a_done", 16'h0); pop_check({15'b0, a_done});
        push("rst_b_out",  16'h0); pop_check(b_out);
        push("rst_b_busy", 16'h0); pop_check({15'b0, b_busy});
        push("rst_c_busy", 16'h0); pop_check({15'b0, c_busy});
        a_rst = 0; b_rst = 0; c_rst = 0;

        // Combinational read: writes visible right after their edge
        a_load = 1; a_addr = 6'd6;  a_in = 16'h0606; tick();
        a_addr = 6'd5;  a_in = 16'hBEEF; tick();
        push("t1_wr_vis", 16'hBEEF); pop_check(a_out);
        a_addr = 6'd63; a_in = 16'h1234; tick();
        a_load = 0;
        a_addr = 6'd5;  push("t1_a5", 16'hBEEF);  #1 pop_check(a_out);
        a_addr = 6'd63; push("t1_a63", 16'h1234); #1 pop_check(a_out);
        a_addr = 6'd6;  push("t1_a6", 16'h0606);  #1 pop_check(a_out);

        // Registered read: write-first and one-cycle latency
        b_load = 1; b_addr = 6'd3; b_in = 16'h3333; tick();
        b_addr = 6'd10; b_in = 16'hA5A5; tick();
        b_load = 0;
        push("t2_wr_first", 16'hA5A5); pop_check(b_out);
        b_addr = 6'd3;
        push("t2_lat0", 16'hA5A5); #1 pop_check(b_out);
        push("t2_lat1", 16'h3333); tick(); pop_check(b_out);

        // Full clear sweep timing and result
        fill_a(16'hFFFF);
        a_clear = 1; tick(); a_clear = 0;
        push("t3_busy_cnt", 16'd64); push("t3_done_cnt", 16'd1); push("t3_done_at", 16'd65);
        sweep_a(0, 0, -1, 0, bc, dc, da);
        pop_check(16'(bc)); pop_check(16'(dc)); pop_check(16'(da));
        for (int i = 0; i < 64; i++) begin
            a_addr = 6'(i);
            push($sformatf("t3_rd%0d", i), 16'h0000);
            #1 pop_check(a_out);
        end

        // Writes and a repeat clear ignored while busy
        fill_a(16'hFFFF);
        a_clear = 1; tick(); a_clear = 0;
        push("t4_busy_cnt", 16'd64); push("t4_done_cnt", 16'd1); push("t4_done_at", 16'd65);
        sweep_a(30, 55, 60, 0, bc, dc, da);
        pop_check(16'(bc)); pop_check(16'(dc)); pop_check(16'(da));
        a_addr = 6'd50; push("t4_a50", 16'h0000); #1 pop_check(a_out);

        // Reset during cycle 20 aborts the sweep before address 19 is written
        fill_a(16'hFFFF);
        a_clear = 1; tick(); a_clear = 0;
        push("t5_busy_cnt", 16'd20); push("t5_done_cnt", 16'd0);
        sweep_a(0, 0, -1, 20, bc, dc, da);
        pop_check(16'(bc)); pop_check(16'(dc));
        for (int i = 0; i < 64; i++) begin
            a_addr = 6'(i);
            push($sformatf("t5_rd%0d", i), (i < 19) ? 16'h0000 : 16'hFFFF);
            #1 pop_check(a_out);
        end

        // Load and clear on the same edge: write lands, then the sweep overwrites it
        a_load = 1; a_clear = 1; a_addr = 6'd0; a_in = 16'h4321; tick();
        a_load = 0; a_clear = 0;
        push("t6_wr_landed", 16'h4321); pop_check(a_out);
        push("t6_busy_cnt", 16'd64);
        sweep_a(0, 0, -1, 0, bc, dc, da);
        pop_check(16'(bc));
        a_addr = 6'd0; push("t6_a0", 16'h0000); #1 pop_check(a_out);

        // Registered read sees sweep writes write-first
        b_load = 1; b_addr = 6'd0; b_in = 16'hCAFE; tick();
        b_load = 0;
        b_clear = 1; tick(); b_clear = 0;
        push("t7_b_old", 16'hCAFE); pop_check(b_out);
        push("t7_b_busy", 16'h1);   pop_check({15'b0, b_busy});
        tick();
        push("t7_b_swept", 16'h0000); pop_check(b_out);
        for (int n = 0; n < 70; n++) tick();
        push("t7_b_idle", 16'h0); pop_check({15'b0, b_busy});

        // Small instance with non-zero fill value
        c_load = 1;
        for (int i = 0; i < 8; i++) begin
            c_addr = 3'(i);
            c_in   = 8'(i * 17);
            tick();
        end
        c_load = 0;
        c_clear = 1; tick(); c_clear = 0;
        bc = 0; dc = 0; da = 0;
        for (int n = 1; n <= 20; n++) begin
            if (c_busy) bc++;
            if (c_done) begin
                dc++;
                if (da == 0) da = n;
            end
            tick();
        end
        push("t8_busy_cnt", 16'd8); pop_check(16'(bc));
        push("t8_done_cnt", 16'd1); pop_check(16'(dc));
        push("t8_done_at", 16'd9);  pop_check(16'(da));
        for (int i = 0; i < 8; i++) begin
            c_addr = 3'(i);
            push($sformatf("t8_rd%0d", i), 16'h005A);
            #1 pop_check({8'h00, c_out});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
